// File: rtl/ps2_key_controller.sv
// ps2_key_controller: PS/2 keyboard receiver with make/break decode and per-player button arbitration
// Ports:
//   clk_50m      system clock, sole clock domain
//   rst_n        synchronous active-low reset
//   kclk, kdata  asynchronous PS/2 clock and data from the keyboard
//   scan_valid   1-cycle pulse, scan_code holds a good byte
//   scan_code    last good byte, held between pulses
//   frame_err    1-cycle pulse on parity, stop or timeout error
//   player1_btns {fire,right,left,down,up} for player 1
//   player2_btns same encoding for player 2
module ps2_key_controller #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic       kclk,
   input  logic       kdata,
   output logic       scan_valid,
   output logic [7:0] scan_code,
   output logic       frame_err,
   output logic [4:0] player1_btns,
   output logic [4:0] player2_btns
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_nxt;
   logic [SYNC_STAGES-1:0] kclk_sr, kdata_sr;
   logic kclk_prev, fall, kd, good, bad, timeout;
   logic [TW-1:0] tcnt;
   logic [2:0] bitcnt, bitcnt_nxt;
   logic [7:0] sr, sr_nxt;
   logic perr, perr_nxt;
   logic [9:0] held, held_nxt, kmask;
   logic brk, brk_nxt, ext, ext_nxt;
   logic [3:0] last1, last1_nxt, last2, last2_nxt;

   assign kd      = kdata_sr[SYNC_STAGES-1];
   assign fall    = kclk_prev & ~kclk_sr[SYNC_STAGES-1];
   assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));

   // Keep the last-made direction while held, otherwise the lowest set bit (up>down>left>right)
   function automatic logic [3:0] arb(input logic [3:0] h, input logic [3:0] l);
      return (|(h & l)) ? l : (h & (~h + 4'd1));
   endfunction

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         kclk_sr   <= '1;
         kdata_sr  <= '1;
         kclk_prev <= 1'b1;
         state     <= IDLE;
         bitcnt    <= '0;
         sr        <= '0;
         perr      <= 1'b0;
         tcnt      <= '0;
         scan_valid <= 1'b0;
         scan_code  <= '0;
         frame_err  <= 1'b0;
      end else begin
         kclk_sr   <= {kclk_sr[SYNC_STAGES-2:0], kclk};
         kdata_sr  <= {kdata_sr[SYNC_STAGES-2:0], kdata};
         kclk_prev <= kclk_sr[SYNC_STAGES-1];
         state     <= state_nxt;
         bitcnt    <= bitcnt_nxt;
         sr        <= sr_nxt;
         perr      <= perr_nxt;
         tcnt      <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
         scan_valid <= good;
         scan_code  <= good ? sr : scan_code;
         frame_err  <= bad;
      end
   end

   always_comb begin
      state_nxt  = state;
      bitcnt_nxt = bitcnt;
      sr_nxt     = sr;
      perr_nxt   = perr;
      good       = 1'b0;
      bad        = 1'b0;
      if (fall) begin
         case (state)
            IDLE: begin
               state_nxt  = kd ? IDLE : DATA;
               bitcnt_nxt = '0;
               perr_nxt   = 1'b0;
            end
            DATA: begin
               sr_nxt[bitcnt] = kd;
               bitcnt_nxt     = bitcnt + 3'd1;
               state_nxt      = (bitcnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               perr_nxt  = ~^{sr, kd};
               state_nxt = STOP;
            end
            STOP: begin
               good      = kd & ~perr;
               bad       = ~good;
               state_nxt = IDLE;
            end
         endcase
      end else if (timeout) begin
         bad       = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_comb begin
      kmask = '0;
      case (scan_code)
         8'h1D: kmask[0] = 1'b1;
         8'h1B: kmask[1] = 1'b1;
         8'h1C: kmask[2] = 1'b1;
         8'h23: kmask[3] = 1'b1;
         8'h29: kmask[4] = 1'b1;
         8'h43: kmask[5] = 1'b1;
         8'h42: kmask[6] = 1'b1;
         8'h3B: kmask[7] = 1'b1;
         8'h4B: kmask[8] = 1'b1;
         8'h5A: kmask[9] = 1'b1;
         default: kmask = '0;
      endcase
   end

   always_comb begin
      held_nxt  = held;
      brk_nxt   = brk;
      ext_nxt   = ext;
      last1_nxt = last1;
      last2_nxt = last2;
      if (scan_valid) begin
         if (scan_code == 8'hF0) begin
            brk_nxt = 1'b1;
         end else if (scan_code == 8'hE0) begin
            ext_nxt = 1'b1;
         end else begin
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
            if (!ext) begin
               held_nxt = brk ? (held & ~kmask) : (held | kmask);
               if (!brk && |kmask[3:0]) last1_nxt = kmask[3:0];
               if (!brk && |kmask[8:5]) last2_nxt = kmask[8:5];
            end
         end
      end
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         held  <= '0;
         brk   <= 1'b0;
         ext   <= 1'b0;
         last1 <= '0;
         last2 <= '0;
         player1_btns <= '0;
         player2_btns <= '0;
      end else begin
         held  <= held_nxt;
         brk   <= brk_nxt;
         ext   <= ext_nxt;
         last1 <= last1_nxt;
         last2 <= last2_nxt;
         player1_btns <= {held_nxt[4], arb(held_nxt[3:0], last1_nxt)};
         player2_btns <= {held_nxt[9], arb(held_nxt[8:5], last2_nxt)};
      end
   end
endmodule

// File: tb/tb_ps2_key_controller.sv
// tb_ps2_key_controller: table-driven scoreboard bench for ps2_key_controller
module tb_ps2_key_controller;
   localparam int TO = 300;
   logic clk_50m = 0, rst_n = 0, kclk = 1, kdata = 1;
   logic scan_valid, frame_err;
   logic [7:0] scan_code;
   logic [4:0] player1_btns, player2_btns;
   int errors = 0, checks = 0, fe_cnt = 0, exp_fe = 0;
   logic [7:0] got_q[$], exp_q[$];

   typedef struct {
      logic [7:0] code;
      bit         bad;
      logic [4:0] p1;
      logic [4:0] p2;
   } vec_t;
   vec_t tbl[0:25];

   ps2_key_controller #(.TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
      .clk_50m(clk_50m), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
      .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err),
      .player1_btns(player1_btns), .player2_btns(player2_btns)
   );

   always #10 clk_50m = ~clk_50m;

   always @(negedge clk_50m) begin
      if (scan_valid) got_q.push_back(scan_code);
      if (frame_err) fe_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         kdata = f[i];
         repeat (10) @(posedge clk_50m);
         kclk = 0;
         repeat (10) @(posedge clk_50m);
         kclk = 1;
      end
      kdata = 1;
   endtask

   task automatic frame(input logic [7:0] c, input bit bad);
      logic par;
      par = ~^c ^ bad;
      if (bad) exp_fe++;
      else exp_q.push_back(c);
      send_bits({1'b1, par, c, 1'b0}, 11);
      repeat (12) @(posedge clk_50m);
   endtask

   task automatic settle(input string name, input logic [4:0] p1, input logic [4:0] p2);
      logic [7:0] e, g;
      @(negedge clk_50m);
      chk({name, " count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         chk({name, " scan_code"}, g, e);
      end
      exp_q.delete();
      got_q.delete();
      chk({name, " frame_err"}, fe_cnt, exp_fe);
      chk({name, " p1"}, player1_btns, p1);
      chk({name, " p2"}, player2_btns, p2);
   endtask

   initial begin
      tbl[0]  = '{8'h1D, 0, 5'b00001, 5'b00000};
      tbl[1]  = '{8'h1C, 0, 5'b00100, 5'b00000};
      tbl[2]  = '{8'hF0, 0, 5'b00100, 5'b00000};
      tbl[3]  = '{8'h1C, 0, 5'b00001, 5'b00000};
      tbl[4]  = '{8'hF0, 0, 5'b00001, 5'b00000};
      tbl[5]  = '{8'h1D, 0, 5'b00000, 5'b00000};
      tbl[6]  = '{8'h1B, 0, 5'b00010, 5'b00000};
      tbl[7]  = '{8'h29, 0, 5'b10010, 5'b00000};
      tbl[8]  = '{8'h5A, 0, 5'b10010, 5'b10000};
      tbl[9]  = '{8'hF0, 0, 5'b10010, 5'b10000};
      tbl[10] = '{8'h5A, 0, 5'b10010, 5'b00000};
      tbl[11] = '{8'hF0, 0, 5'b10010, 5'b00000};
      tbl[12] = '{8'h29, 0, 5'b00010, 5'b00000};
      tbl[13] = '{8'hF0, 0, 5'b00010, 5'b00000};
      tbl[14] = '{8'h1B, 0, 5'b00000, 5'b00000};
      tbl[15] = '{8'h43, 1, 5'b00000, 5'b00000};
      tbl[16] = '{8'h15, 0, 5'b00000, 5'b00000};
      tbl[17] = '{8'h43, 0, 5'b00000, 5'b00001};
      tbl[18] = '{8'h4B, 0, 5'b00000, 5'b01000};
      tbl[19] = '{8'h43, 0, 5'b00000, 5'b00001};
      tbl[20] = '{8'hF0, 0, 5'b00000, 5'b00001};
      tbl[21] = '{8'h43, 0, 5'b00000, 5'b01000};
      tbl[22] = '{8'hF0, 0, 5'b00000, 5'b01000};
      tbl[23] = '{8'h29, 0, 5'b00000, 5'b01000};
      tbl[24] = '{8'hF0, 0, 5'b00000, 5'b01000};
      tbl[25] = '{8'h4B, 0, 5'b00000, 5'b00000};
      repeat (5) @(posedge clk_50m);
      @(negedge clk_50m);
      chk("reset scan_valid", scan_valid, 0);
      chk("reset scan_code", scan_code, 0);
      chk("reset frame_err", frame_err, 0);
      chk("reset p1", player1_btns, 0);
      chk("reset p2", player2_btns, 0);
      @(posedge clk_50m);
      rst_n = 1;
      repeat (5) @(posedge clk_50m);
      for (int i = 0; i < 26; i++) begin
         frame(tbl[i].code, tbl[i].bad);
         settle($sformatf("vec%0d", i), tbl[i].p1, tbl[i].p2);
      end
      send_bits(11'b000_1010_0100, 5);
      exp_fe++;
      repeat (TO + 50) @(posedge clk_50m);
      settle("timeout", 5'b00000, 5'b00000);
      frame(8'h42, 0);
      settle("after timeout", 5'b00000, 5'b00010);
      frame(8'hF0, 0);
      frame(8'h42, 0);
      settle("release 42", 5'b00000, 5'b00000);
      frame(8'hE0, 0);
      frame(8'h1D, 0);
      settle("ext 1D", 5'b00000, 5'b00000);
      frame(8'h1B, 0);
      settle("hold 1B", 5'b00010, 5'b00000);
      send_bits(11'b000_0101_1010, 4);
      @(posedge clk_50m);
      rst_n = 0;
      repeat (3) @(posedge clk_50m);
      @(negedge clk_50m);
      chk("midreset scan_valid", scan_valid, 0);
      chk("midreset scan_code", scan_code, 0);
      chk("midreset frame_err", frame_err, 0);
      chk("midreset p1", player1_btns, 0);
      chk("midreset p2", player2_btns, 0);
      @(posedge clk_50m);
      rst_n = 1;
      repeat (5) @(posedge clk_50m);
      frame(8'h4B, 0);
      settle("after reset", 5'b00000, 5'b01000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
